// File: rtl/led_sweep_ctrl.sv
// Sweep sequencer for the LED shift register: turns rate ticks into load/shift/direction
// strobes that bounce a seed pattern back and forth, and flips the display colour per pattern cycle.
module led_sweep_ctrl #(
   parameter int LED_WIDTH   = 4,
   parameter int PASSES      = 2,
   parameter int PAUSE_TICKS = 3
) (
   input  logic                 clock,
   input  logic                 i_reset,
   input  logic                 i_enable,
   input  logic                 i_tick,
   input  logic [1:0]           i_mode,
   output logic                 o_load,
   output logic [LED_WIDTH-1:0] o_load_val,
   output logic                 o_shift,
   output logic                 o_dir,
   output logic                 o_color,
   output logic                 o_pass_done,
   output logic [1:0]           o_state
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      SWEEP = 2'd2,
      PAUSE = 2'd3
   } state_t;

   localparam int SHIFT_W = $clog2(LED_WIDTH);
   localparam int PASS_W  = $clog2(PASSES + 1);
   localparam int PAUSE_W = $clog2(PAUSE_TICKS + 1);

   // Counter values on the tick that completes a pass, a pattern cycle, and a pause
   localparam logic [SHIFT_W-1:0] SHIFT_END = SHIFT_W'(LED_WIDTH - 2);
   localparam logic [PASS_W-1:0]  PASS_END  = PASS_W'(PASSES - 1);
   localparam logic [PAUSE_W-1:0] PAUSE_END = PAUSE_W'(PAUSE_TICKS - 1);

   state_t               state;
   logic                 dir_reg;
   logic [SHIFT_W-1:0]   shift_cnt;
   logic [PASS_W-1:0]    pass_cnt;
   logic [PAUSE_W-1:0]   pause_cnt;
   logic [LED_WIDTH-1:0] seed_val;
   logic                 seed_dir;
   logic [LED_WIDTH-1:0] alt_pattern;

   always_comb begin
      alt_pattern = '0;
      for (int i = 0; i < LED_WIDTH; i += 2) alt_pattern[i] = 1'b1;
      seed_val = '0;
      seed_dir = 1'b0;
      case (i_mode)
         2'd0: seed_val = LED_WIDTH'(1);
         2'd1: seed_val = LED_WIDTH'(3);
         2'd2: seed_val = alt_pattern;
         default: begin
            seed_val = {1'b1, {(LED_WIDTH-1){1'b0}}};
            seed_dir = 1'b1;
         end
      endcase
   end

   // Strobes default low each cycle; disable preempts any tick in flight
   always_ff @(posedge clock) begin
      if (!i_reset) begin
         state       <= IDLE;
         o_load      <= 1'b0;
         o_load_val  <= '0;
         o_shift     <= 1'b0;
         o_dir       <= 1'b0;
         o_color     <= 1'b0;
         o_pass_done <= 1'b0;
         dir_reg     <= 1'b0;
         shift_cnt   <= '0;
         pass_cnt    <= '0;
         pause_cnt   <= '0;
      end else begin
         o_load      <= 1'b0;
         o_shift     <= 1'b0;
         o_pass_done <= 1'b0;
         if (state != IDLE && !i_enable) begin
            state     <= IDLE;
            shift_cnt <= '0;
            pass_cnt  <= '0;
            pause_cnt <= '0;
         end else begin
            case (state)
               IDLE: begin
                  if (i_enable) begin
                     state      <= LOAD;
                     o_load     <= 1'b1;
                     o_load_val <= seed_val;
                     o_dir      <= seed_dir;
                     dir_reg    <= seed_dir;
                     shift_cnt  <= '0;
                     pass_cnt   <= '0;
                  end
               end
               LOAD: state <= SWEEP;
               SWEEP: begin
                  if (i_tick) begin
                     o_shift <= 1'b1;
                     o_dir   <= dir_reg;
                     if (shift_cnt == SHIFT_END) begin
                        shift_cnt <= '0;
                        dir_reg   <= ~dir_reg;
                        pass_cnt  <= pass_cnt + 1'b1;
                        if (pass_cnt == PASS_END) begin
                           o_pass_done <= 1'b1;
                           o_color     <= ~o_color;
                           pause_cnt   <= '0;
                           state       <= PAUSE;
                        end
                     end else begin
                        shift_cnt <= shift_cnt + 1'b1;
                     end
                  end
               end
               PAUSE: begin
                  if (i_tick) begin
                     if (pause_cnt == PAUSE_END) begin
                        pause_cnt  <= '0;
                        state      <= LOAD;
                        o_load     <= 1'b1;
                        o_load_val <= seed_val;
                        o_dir      <= seed_dir;
                        dir_reg    <= seed_dir;
                        shift_cnt  <= '0;
                        pass_cnt   <= '0;
                     end else begin
                        pause_cnt <= pause_cnt + 1'b1;
                     end
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

   assign o_state = state;

endmodule

// File: doc/led_sweep_ctrl.md
# led_sweep_ctrl

Sequencer for the LED shift-register datapath. It turns the rate counter's one-cycle tick into load, shift and direction commands for the shift register, producing bouncing sweep patterns. It selects the display colour (green/blue) and toggles it after a programmed number of sweep passes. It sits between the tick generator and the LED shift register; the colour bit drives the green/blue output steering.

## Interface
- LED_WIDTH, 4, width of the LED shift register; minimum 2.
- PASSES, 2, one-direction passes per pattern cycle; minimum 1.
- PAUSE_TICKS, 3, ticks idled between pattern cycles; minimum 1.

- clock  in  1  single clock; all state changes on rising edge.
- i_reset  in  1  synchronous, active-low reset.
- i_enable  in  1  run request; level-sensitive.
- i_tick  in  1  one-cycle rate pulse from tick counter; may be high on consecutive cycles.
- i_mode  in  2  pattern select; sampled only on entry to LOAD.
- o_load  out  1  one-cycle parallel-load strobe to shift register.
- o_load_val  out  LED_WIDTH  seed value; valid while o_load=1, held afterwards.
- o_shift  out  1  one-cycle shift strobe.
- o_dir  out  1  direction of the current/last shift: 0 = left (toward MSB), 1 = right.
- o_color  out  1  0 = green, 1 = blue.
- o_pass_done  out  1  one-cycle pulse on the final shift of a pattern cycle.
- o_state  out  2  current state, for debug: IDLE=0, LOAD=1, SWEEP=2, PAUSE=3.

## Operation
- Reset (i_reset=0 at an edge):
  - state = IDLE.
  - All outputs = 0.
  - Shift counter, pass counter and pause counter = 0.
  - Reset overrides every other input.
- Seeds by i_mode:
  - 0 → 0…01, dir 0.
  - 1 → 0…011, dir 0.
  - 2 → alternating 0101… (LSB=1), dir 0.
  - 3 → 10…0, dir 1.
- IDLE: i_enable=1 → LOAD.
- Entering LOAD (from IDLE or PAUSE):
  - o_load ← 1; o_load_val ← seed(i_mode); o_dir ← seed direction.
  - Internal direction register ← seed direction.
  - Shift counter and pass counter ← 0.
- LOAD: lasts exactly one cycle → SWEEP; o_load ← 0. A tick during LOAD is ignored.
- SWEEP, on each i_tick:
  - o_shift ← 1 and o_dir ← internal direction; shift counter += 1.
  - When the shift counter reaches LED_WIDTH−1, the pass ends:
    - internal direction toggles and the shift counter clears;
    - pass counter += 1.
  - When the pass counter reaches PASSES:
    - o_pass_done ← 1 (same cycle as that final o_shift);
    - o_color toggles and state → PAUSE.
- PAUSE:
  - Each tick increments the pause counter; no shift is issued.
  - At the PAUSE_TICKS-th tick the pause counter clears and state → LOAD, which re-samples i_mode.
- i_enable=0 in any non-IDLE state:
  - Next edge: state → IDLE.
  - o_load, o_shift, o_pass_done ← 0.
  - Shift, pass and pause counters clear.
- o_color and o_dir are retained across disable; only reset clears them.
- Simultaneous events:
  - i_enable=0 together with i_tick: disable wins; no shift is issued.
  - Re-enable after disable always restarts at LOAD.
- Counters saturate only by design: shift counter ≤ LED_WIDTH−1, pass counter ≤ PASSES, pause counter ≤ PAUSE_TICKS. No wrap-around is observable.

## Timing
- All outputs are registered. No combinational path runs from any input to any output.
- Enable to load: i_enable sampled high at edge E in IDLE → o_load=1 during cycle E..E+1 → state SWEEP from E+1.
- Tick to shift: i_tick high at edge T in SWEEP → o_shift=1 for exactly the cycle after T. o_dir is valid in the same cycle.
- Back-to-back ticks produce back-to-back o_shift pulses; a direction change applies from the next pulse.
- o_pass_done and the o_color toggle appear in the same cycle as the last o_shift.
- The PAUSE→LOAD transition occurs at the edge sampling the final pause tick.
- Reset mid-sweep takes effect at the next edge; all outputs read 0 in the following cycle.

## Test plan
- Reset with i_enable=1, then release (LED_WIDTH=4, PASSES=2, PAUSE_TICKS=3):
  - outputs all 0 while in reset;
  - o_load=1 with o_load_val=0001 one cycle after release;
  - o_state sequence 0→1→2.
- Mode 0, tick every 4 cycles:
  - 3 shifts with o_dir=0, then 3 shifts with o_dir=1;
  - o_pass_done and o_color 0→1 on the 6th shift;
  - 3 ticks with no shift;
  - then o_load with 0001 again.
- Mode 3 with i_tick held high continuously:
  - seed 1000, o_dir=1;
  - six consecutive o_shift cycles with directions 1,1,1,0,0,0;
  - o_pass_done on the 6th.
- i_mode changed from 0 to 2 during SWEEP: no effect until the next LOAD, which loads 0101.
- i_enable dropped in the same cycle as a tick mid-pass:
  - no o_shift; o_state=0 next cycle; o_color retained;
  - on re-enable, o_load is re-issued and the pass count restarts at 0.
- i_reset asserted during PAUSE with o_color=1:
  - all outputs and o_state = 0 the next cycle;
  - after release with i_enable=1, a fresh LOAD follows.
